// File: rtl/vga_pkg.sv
// Shared VGA timing package: default 640x480@60 timing constants, the lock
// FSM state encoding and the colour triple used by the sync generator and
// the sync decoder.
package vga_pkg;

  // Default horizontal timing, in pixel clocks
  localparam int H_SYNC_DEF  = 96;
  localparam int H_BACK_DEF  = 48;
  localparam int H_ACT_DEF   = 640;
  localparam int H_TOTAL_DEF = 800;

  // Default vertical timing, in lines
  localparam int V_SYNC_DEF  = 2;
  localparam int V_BACK_DEF  = 33;
  localparam int V_ACT_DEF   = 480;
  localparam int V_TOTAL_DEF = 525;

  // Counter and colour widths
  localparam int HCNT_W = 11;
  localparam int VCNT_W = 10;
  localparam int COL_W  = 10;

  localparam logic [HCNT_W-1:0] HCNT_MAX = '1;
  localparam logic [VCNT_W-1:0] VCNT_MAX = '1;

  // Lock tracker states
  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } lock_state_e;

  typedef struct packed {
    logic [COL_W-1:0] r;
    logic [COL_W-1:0] g;
    logic [COL_W-1:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_sync_edge.sv
// Stage-1 input register for one active-low sync plus falling-edge detect.
// The previous-value flop resets high so a sync that idles high after reset
// release never looks like an edge.
module vga_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sync_n,
  output logic fall
);

  logic s1_q, s1_d;
  logic prev_q, prev_d;

  // Next values: sample the pin, remember the last sample
  always_comb begin
    s1_d   = sync_n;
    prev_d = s1_q;
  end

  // Sync register pair, idle-high on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= s1_d;
      prev_q <= prev_d;
    end
  end

  assign fall = prev_q & ~s1_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: recovers pixel coordinates from hsync/vsync, measures
// line length and frame height, and tracks lock against the nominal timing
// (SEARCH -> MEASURE -> LOCKED). Colour is delayed to line up with the
// recovered coordinates two clocks after the input sample.
// Optional build macro VGA_DEC_CHECKSUM_EN adds a per-frame R+G+B checksum on
// oFrame_Sum; without it oFrame_Sum is tied to zero.
module vga_sync_decoder
  import vga_pkg::*;
#(
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BACK  = H_BACK_DEF,
  parameter int H_ACT   = H_ACT_DEF,
  parameter int H_TOTAL = H_TOTAL_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BACK  = V_BACK_DEF,
  parameter int V_ACT   = V_ACT_DEF,
  parameter int V_TOTAL = V_TOTAL_DEF
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iVGA_H_SYNC,
  input  logic              iVGA_V_SYNC,
  input  logic [COL_W-1:0]  iVGA_R,
  input  logic [COL_W-1:0]  iVGA_G,
  input  logic [COL_W-1:0]  iVGA_B,
  output logic [9:0]        oCoord_X,
  output logic [9:0]        oCoord_Y,
  output logic [COL_W-1:0]  oPix_R,
  output logic [COL_W-1:0]  oPix_G,
  output logic [COL_W-1:0]  oPix_B,
  output logic              oPix_Valid,
  output logic              oFrame_Start,
  output logic              oLocked,
  output logic              oErr,
  output logic [HCNT_W-1:0] oLine_Len,
  output logic [VCNT_W-1:0] oFrame_Lines,
  output logic [15:0]       oFrame_Sum
);

  // Active window bounds at counter width
  localparam logic [HCNT_W-1:0] H_ACT_LO  = HCNT_W'(H_SYNC + H_BACK);
  localparam logic [HCNT_W-1:0] H_ACT_HI  = HCNT_W'(H_SYNC + H_BACK + H_ACT - 1);
  localparam logic [VCNT_W-1:0] V_ACT_LO  = VCNT_W'(V_SYNC + V_BACK);
  localparam logic [VCNT_W-1:0] V_ACT_HI  = VCNT_W'(V_SYNC + V_BACK + V_ACT - 1);
  localparam logic [HCNT_W-1:0] H_TOTAL_W = HCNT_W'(H_TOTAL);
  localparam logic [VCNT_W-1:0] V_TOTAL_W = VCNT_W'(V_TOTAL);

  // ---------------------------------------------------------------------
  // Stage 1: sync edge detect (bit 0 = hsync, bit 1 = vsync)
  // ---------------------------------------------------------------------
  logic [1:0] sync_n;
  logic [1:0] sync_fall;
  logic       hs_fall, vs_fall;

  assign sync_n = {iVGA_V_SYNC, iVGA_H_SYNC};

  for (genvar i = 0; i < 2; i++) begin : g_edge
    vga_sync_edge u_edge (
      .clk    (iCLK),
      .rst    (iRST),
      .sync_n (sync_n[i]),
      .fall   (sync_fall[i])
    );
  end

  assign hs_fall = sync_fall[0];
  assign vs_fall = sync_fall[1];

  // ---------------------------------------------------------------------
  // Colour pipeline: stage 1 register, stage 2 aligns with the counters
  // ---------------------------------------------------------------------
  rgb_t rgb_s1_q, rgb_s1_d;
  rgb_t rgb_s2_q, rgb_s2_d;

  // Colour delay line next values
  always_comb begin
    rgb_s1_d = {iVGA_R, iVGA_G, iVGA_B};
    rgb_s2_d = rgb_s1_q;
  end

  // Colour delay line registers
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      rgb_s1_q <= '0;
      rgb_s2_q <= '0;
    end else begin
      rgb_s1_q <= rgb_s1_d;
      rgb_s2_q <= rgb_s2_d;
    end
  end

  // ---------------------------------------------------------------------
  // Position counters and measurements
  // ---------------------------------------------------------------------
  logic [HCNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [VCNT_W-1:0] v_cnt_q, v_cnt_d;
  logic [HCNT_W-1:0] line_len_q, line_len_d;
  logic [VCNT_W-1:0] frame_lines_q, frame_lines_d;
  logic [HCNT_W-1:0] line_len_now;
  logic [VCNT_W-1:0] frame_lines_now;

  // Saturating counters; vsync fall beats a coincident hsync fall on v_cnt
  always_comb begin
    line_len_now    = (h_cnt_q == HCNT_MAX) ? HCNT_MAX : h_cnt_q + 1'b1;
    frame_lines_now = (v_cnt_q == VCNT_MAX) ? VCNT_MAX : v_cnt_q + 1'b1;

    h_cnt_d = h_cnt_q;
    if (hs_fall)                 h_cnt_d = '0;
    else if (h_cnt_q != HCNT_MAX) h_cnt_d = h_cnt_q + 1'b1;

    v_cnt_d = v_cnt_q;
    if (vs_fall)                            v_cnt_d = '0;
    else if (hs_fall && v_cnt_q != VCNT_MAX) v_cnt_d = v_cnt_q + 1'b1;

    line_len_d    = hs_fall ? line_len_now    : line_len_q;
    frame_lines_d = vs_fall ? frame_lines_now : frame_lines_q;
  end

  // Counter and measurement registers
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
    end
  end

  // ---------------------------------------------------------------------
  // Lock FSM
  // ---------------------------------------------------------------------
  lock_state_e state_q, state_d;
  logic        bad_q, bad_d;
  logic        err_q, err_d;
  logic        fs_q, fs_d;
  logic        line_bad, frame_bad;

  // Next state: a frame is good when every line and the line count match
  always_comb begin
    line_bad  = hs_fall && (line_len_now != H_TOTAL_W);
    frame_bad = (frame_lines_now != V_TOTAL_W);
    state_d   = state_q;
    bad_d     = bad_q;
    err_d     = 1'b0;
    fs_d      = vs_fall;
    case (state_q)
      ST_SEARCH: begin
        if (vs_fall) begin
          state_d = ST_MEASURE;
          bad_d   = 1'b0;
        end
      end
      ST_MEASURE: begin
        if (line_bad) bad_d = 1'b1;
        if (vs_fall) begin
          // The line ending on this vsync fall belongs to the frame being judged
          bad_d = 1'b0;
          if (bad_q || line_bad || frame_bad) err_d   = 1'b1;
          else                                state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (line_bad || (h_cnt_q == HCNT_MAX) || (vs_fall && frame_bad)) begin
          err_d   = 1'b1;
          state_d = ST_SEARCH;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  // Lock FSM registers
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= ST_SEARCH;
      bad_q   <= 1'b0;
      err_q   <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
      fs_q    <= fs_d;
    end
  end

  // ---------------------------------------------------------------------
  // Pixel output stage
  // ---------------------------------------------------------------------
  logic              pix_valid_q, pix_valid_d;
  logic [9:0]        coord_x_q, coord_x_d;
  logic [9:0]        coord_y_q, coord_y_d;
  rgb_t              pix_q, pix_d;

  // Valid only inside the active window while locked; hold otherwise
  always_comb begin
    pix_valid_d = (state_q == ST_LOCKED) &&
                  (h_cnt_q >= H_ACT_LO) && (h_cnt_q <= H_ACT_HI) &&
                  (v_cnt_q >= V_ACT_LO) && (v_cnt_q <= V_ACT_HI);
    coord_x_d = coord_x_q;
    coord_y_d = coord_y_q;
    pix_d     = pix_q;
    if (pix_valid_d) begin
      coord_x_d = 10'(h_cnt_q - H_ACT_LO);
      coord_y_d = 10'(v_cnt_q - V_ACT_LO);
      pix_d     = rgb_s2_q;
    end
  end

  // Pixel output registers
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      pix_valid_q <= 1'b0;
      coord_x_q   <= '0;
      coord_y_q   <= '0;
      pix_q       <= '0;
    end else begin
      pix_valid_q <= pix_valid_d;
      coord_x_q   <= coord_x_d;
      coord_y_q   <= coord_y_d;
      pix_q       <= pix_d;
    end
  end

  // ---------------------------------------------------------------------
  // Optional frame checksum
  // ---------------------------------------------------------------------
`ifdef VGA_DEC_CHECKSUM_EN
  logic [15:0] acc_q, acc_d;
  logic [15:0] sum_q, sum_d;
  logic [15:0] px_sum;

  // Accumulate valid pixels; publish and restart on vsync fall
  always_comb begin
    px_sum = pix_valid_d ? (16'(rgb_s2_q.r) + 16'(rgb_s2_q.g) + 16'(rgb_s2_q.b)) : 16'd0;
    acc_d  = acc_q + px_sum;
    sum_d  = sum_q;
    if (vs_fall) begin
      sum_d = acc_q + px_sum;
      acc_d = '0;
    end
  end

  // Checksum registers
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      acc_q <= '0;
      sum_q <= '0;
    end else begin
      acc_q <= acc_d;
      sum_q <= sum_d;
    end
  end

  assign oFrame_Sum = sum_q;
`else
  assign oFrame_Sum = '0;
`endif

  assign oCoord_X     = coord_x_q;
  assign oCoord_Y     = coord_y_q;
  assign oPix_R       = pix_q.r;
  assign oPix_G       = pix_q.g;
  assign oPix_B       = pix_q.b;
  assign oPix_Valid   = pix_valid_q;
  assign oFrame_Start = fs_q;
  assign oLocked      = (state_q == ST_LOCKED);
  assign oErr         = err_q;
  assign oLine_Len    = line_len_q;
  assign oFrame_Lines = frame_lines_q;

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameter H_SYNC, 96, hsync pulse width in clocks.
REQ-002 SHALL have parameter H_BACK, 48, horizontal back porch in clocks.
REQ-003 SHALL have parameter H_ACT, 640, active pixels per line.
REQ-004 SHALL have parameter H_TOTAL, 800, clocks per line.
REQ-005 SHALL have parameters V_SYNC 2, V_BACK 33, V_ACT 480, V_TOTAL 525, same meanings in lines.
REQ-006 SHALL have port iCLK  in  1  pixel clock, the single clock.
REQ-007 SHALL have port iRST  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have ports iVGA_H_SYNC, iVGA_V_SYNC  in  1  syncs, active low.
REQ-009 SHALL have ports iVGA_R, iVGA_G, iVGA_B  in  10 each  pixel colour.
REQ-010 SHALL have ports oCoord_X, oCoord_Y  out  10 each  recovered pixel position.
REQ-011 SHALL have ports oPix_R, oPix_G, oPix_B  out  10 each  colour aligned with coordinates.
REQ-012 SHALL have port oPix_Valid  out  1  active-area pixel strobe.
REQ-013 SHALL have ports oFrame_Start  out  1  one-cycle pulse per vsync fall; oLocked  out  1; oErr  out  1  one-cycle timing-error pulse.
REQ-014 SHALL have ports oLine_Len  out  11  last measured line length; oFrame_Lines  out  10  last measured line count.

Function
REQ-015 SHALL register all inputs once (stage 1), detecting sync falling edges from stage-1 value vs its previous value.
REQ-016 SHALL zero the 11-bit h_cnt on the cycle of an hsync falling edge; otherwise increment, saturating at 2047.
REQ-017 SHALL zero v_cnt on a vsync falling edge, otherwise increment on each hsync falling edge, saturating at 1023; vsync fall wins when simultaneous.
REQ-018 SHALL, on each hsync fall, load oLine_Len with h_cnt+1 (clocks in the previous line); on each vsync fall, load oFrame_Lines with v_cnt+1.
REQ-019 SHALL assert oPix_Valid when oLocked, h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACT-1] and v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACT-1].
REQ-020 SHALL output oCoord_X = h_cnt-(H_SYNC+H_BACK) and oCoord_Y = v_cnt-(V_SYNC+V_BACK) with the matching colour, 2 cycles after the input sample; coordinates/colour hold when oPix_Valid is low.
REQ-021 SHALL implement lock FSM SEARCH -> MEASURE on first vsync fall.
REQ-022 SHALL, in MEASURE, flag a line bad if line length != H_TOTAL; at next vsync fall go LOCKED if no bad line and line count == V_TOTAL, else stay MEASURE and pulse oErr.
REQ-023 SHALL, in LOCKED, on any bad line, line count mismatch or h_cnt saturation, pulse oErr, deassert oLocked next cycle, go SEARCH.
REQ-024 SHALL pulse oFrame_Start on every vsync fall regardless of lock state.

Reset
REQ-025 SHALL on iRST clear all counters, force FSM to SEARCH, all outputs to 0, and treat stage-1 previous sync values as 1 (no false edge after release).
REQ-026 SHALL abandon any partial measurement on reset mid-frame; first post-reset vsync fall starts MEASURE.

Configuration
REQ-027 SHALL, when VGA_DEC_CHECKSUM_EN is defined, add output oFrame_Sum (16) = modulo-2^16 sum of R+G+B over valid pixels, updated at vsync fall, accumulator cleared same cycle.
REQ-028 SHALL, when VGA_DEC_CHECKSUM_EN is undefined, omit accumulator logic and drive oFrame_Sum to 0.

Structure
REQ-029 SHALL take default timing constants and FSM state encoding from shared package vga_pkg, also used by the sync generator.
REQ-030 SHALL instantiate sub-module vga_sync_edge (input register plus falling-edge detect) once per sync.

Verification
REQ-031 SHALL cover: reset, two clean 800x525 frames -> oLocked rises one cycle after second vsync fall, oErr never.
REQ-032 SHALL cover: locked, pixel at h_cnt=144, v_cnt=35 -> oCoord 0,0, oPix_Valid 2 cycles later; h_cnt=783 -> X=639.
REQ-033 SHALL cover: locked, one line of 801 clocks -> oErr pulse, oLocked low, oLine_Len=801, FSM SEARCH.
REQ-034 SHALL cover: frame of 524 lines in MEASURE -> oErr pulse, oFrame_Lines=524, stays unlocked.
REQ-035 SHALL cover: iRST asserted mid-line while locked -> all outputs 0 immediately, relock after two clean frames.
REQ-036 SHALL cover (VGA_DEC_CHECKSUM_EN): constant R=G=B=1 frame -> oFrame_Sum = 921600 mod 65536 = 4096.
